pc_sequencer: RTL

Parametrised program-counter sequencer for the instruction-fetch stage. It generalises the basic PC-update path with a configurable address width, reset and exception vectors, and a fetch stall. It adds register-indirect jumps, exception entry and return via an EPC register, and a circular return-address stack (RAS) that predicts `jr $ra` targets. It sits between the decode/branch logic and the instruction memory address port.

---
 rtl/pc_sequencer.sv | 95 +++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC with branches, jumps, exception entry/return and a circular return-address stack.
module pc_sequencer #(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(32'h0000_0180),
    parameter int                RAS_DEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         stall,
    input  logic                         branch_select,
    input  logic                         jump_enable,
    input  logic                         jump_link,
    input  logic                         jump_reg,
    input  logic                         ret_enable,
    input  logic                         exception,
    input  logic                         eret,
    input  logic [ADDR_W-1:0]            sign_extended_immediate,
    input  logic [25:0]                  jump_address,
    input  logic [ADDR_W-1:0]            jump_reg_addr,
    output logic [ADDR_W-1:0]            pc,
    output logic [ADDR_W-1:0]            epc,
    output logic [ADDR_W-1:0]            ras_top,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         addr_error
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] pc_q, pc_d, epc_q, epc_d;
    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
    logic [PW-1:0]     wp_q, wp_d, top_idx, wr_idx;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              aerr_q, aerr_d;
    logic [ADDR_W-1:0] pc_plus_4, branch_target, jump_target;
    logic              trap, go, push, pop;

    always_comb begin
        pc_plus_4     = pc_q + ADDR_W'(4);
        branch_target = pc_plus_4 + {sign_extended_immediate[ADDR_W-3:0], 2'b00};
        jump_target   = {pc_plus_4[ADDR_W-1:28], jump_address, 2'b00};
        trap          = jump_reg && (jump_reg_addr[1:0] != 2'b00);
        go            = !stall && !exception && !eret && !trap;
        push          = go && jump_link && (jump_enable || jump_reg);
        // a pop on an empty stack is dropped, so push+pop when empty degrades to a plain push
        pop           = go && jump_reg && ret_enable && (cnt_q != '0);
        top_idx       = wp_q - PW'(1);
        wr_idx        = pop ? top_idx : wp_q;
        wp_d          = (push && !pop) ? wp_q + PW'(1) : (pop && !push) ? top_idx : wp_q;
        cnt_d         = (push && !pop && cnt_q != CW'(RAS_DEPTH)) ? cnt_q + CW'(1)
                      : (pop && !push) ? cnt_q - CW'(1) : cnt_q;
        pc_d          = pc_q;
        epc_d         = epc_q;
        aerr_d        = 1'b0;
        if (exception) begin
            pc_d  = EXC_VECTOR;
            epc_d = pc_q;
        end else if (!stall) begin
            if (eret) begin
                pc_d = epc_q;
            end else if (trap) begin
                pc_d   = EXC_VECTOR;
                epc_d  = pc_q;
                aerr_d = 1'b1;
            end else begin
                pc_d = jump_reg ? jump_reg_addr : jump_enable ? jump_target
                     : branch_select ? branch_target : pc_plus_4;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q   <= RESET_VECTOR;
            epc_q  <= '0;
            wp_q   <= '0;
            cnt_q  <= '0;
            aerr_q <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
        end else begin
            pc_q   <= pc_d;
            epc_q  <= epc_d;
            wp_q   <= wp_d;
            cnt_q  <= cnt_d;
            aerr_q <= aerr_d;
            if (push) ras_q[wr_idx] <= pc_plus_4;
        end
    end

    assign pc         = pc_q;
    assign epc        = epc_q;
    assign ras_count  = cnt_q;
    assign ras_top    = (cnt_q == '0) ? '0 : ras_q[top_idx];
    assign addr_error = aerr_q;
endmodule
